// File: rtl/ripple_sampler_pkg.sv
// Shared types and defaults for the ripple counter sampler.
// Imported by the sampler top and its synchroniser.
package ripple_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 2;

endpackage

// File: rtl/d_ff_sync.sv
// Single synchroniser flop with synchronous active-high reset.
// Building block of the per-bit resync chain.
module d_ff_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/sync_chain.sv
// Per-bit flop chain that resynchronises an async bus into clk.
// Output is the last stage; depth is STAGES flops.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES:0][WIDTH-1:0] stg;

  assign stg[0] = d_i;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      d_ff_sync u_ff (
        .clk (clk),
        .rst (rst),
        .d_i (stg[s][b]),
        .q_o (stg[s+1][b])
      );
    end
  end

  assign q_o = stg[STAGES];

endmodule

// File: rtl/ripple_count_sampler.sv
// Resyncs a ripple counter, filters transients, and emits each
// settled value with a direction-signed delta and terminal pulse.
module ripple_count_sampler
  import ripple_sampler_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             up,
  input  logic [WIDTH-1:0] term_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_count,
  output logic [WIDTH-1:0] out_delta,
  output logic             tc_pulse
);

  localparam logic [4:0] STAB_LAST = 5'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync_q;
  state_e           state_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] cand_q;
  logic [3:0]       stab_q;
  logic             valid_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] delta_q;
  logic             tc_q;

  logic [WIDTH-1:0] delta_d;
  logic [4:0]       stab_d;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cnt_in),
    .q_o (sync_q)
  );

  // Modulo-2^WIDTH subtraction gives the wrap for free.
  assign delta_d = up ? cand_q - last_q
                      : last_q - cand_q;
  assign stab_d  = {1'b0, stab_q} + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      delta_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync_q != last_q) begin
            cand_q  <= sync_q;
            stab_q  <= 4'd1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync_q == last_q) begin
            state_q <= IDLE;
          end else if (sync_q != cand_q) begin
            cand_q <= sync_q;
            stab_q <= 4'd1;
          end else if (stab_d == STAB_LAST) begin
            count_q <= cand_q;
            last_q  <= cand_q;
            delta_q <= delta_d;
            tc_q    <= (cand_q == term_val);
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            stab_q <= stab_d[3:0];
          end
        end
        HOLD: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_delta = delta_q;
  assign tc_pulse  = tc_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Scoreboard bench: run-length reference model feeds a queue,
// a negedge monitor compares every new sample the DUT presents.
module tb_ripple_count_sampler;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int SC = 2;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic [W-1:0] cnt_in    = '0;
  logic         up        = 1'b1;
  logic [W-1:0] term_val  = 4'd9;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_count;
  logic [W-1:0] out_delta;
  logic         tc_pulse;

  ripple_count_sampler #(
    .WIDTH         (W),
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .up        (up),
    .term_val  (term_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_delta (out_delta),
    .tc_pulse  (tc_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] dlt;
    logic         tc;
  } exp_t;

  exp_t sb[$];
  int tests   = 0;
  int fails   = 0;
  int samples = 0;
  logic [W-1:0] seen_cnt = '0;
  logic [W-1:0] seen_dlt = '0;
  logic         seen_tc  = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: sampled value lags cnt_in by SS edges; a value is
  // accepted once it has been seen SC times in a row while no
  // sample is pending, and only if it differs from the last one.
  logic [W-1:0] dl [SS];
  logic [W-1:0] m_last  = '0;
  logic [W-1:0] run_val = '0;
  int           run_len = 0;
  bit           pend    = 1'b0;

  initial foreach (dl[i]) dl[i] = '0;

  always @(posedge clk) begin
    logic [W-1:0] s;
    exp_t e;
    s = dl[SS-1];
    for (int i = SS - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = cnt_in;
    if (rst) begin
      foreach (dl[i]) dl[i] = '0;
      m_last  = '0;
      run_len = 0;
      pend    = 1'b0;
    end else if (pend) begin
      if (out_ready) begin
        pend    = 1'b0;
        run_len = 0;
      end
    end else begin
      if (run_len > 0 && s == run_val) run_len++;
      else begin
        run_val = s;
        run_len = 1;
      end
      if (s != m_last && run_len >= SC) begin
        e.cnt = s;
        e.dlt = up ? W'(s - m_last) : W'(m_last - s);
        e.tc  = (s == term_val);
        sb.push_back(e);
        m_last  = s;
        pend    = 1'b1;
        run_len = 0;
      end
    end
  end

  logic pv = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !pv) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample: got count %0d expected none",
                 out_count);
      end else begin
        e = sb.pop_front();
        check("sample_count", out_count, e.cnt);
        check("sample_delta", out_delta, e.dlt);
        check("sample_tc", tc_pulse, e.tc);
      end
      seen_cnt = out_count;
      seen_dlt = out_delta;
      seen_tc  = tc_pulse;
      samples++;
    end else if (out_valid) begin
      check("held_count", out_count, seen_cnt);
      check("held_delta", out_delta, seen_dlt);
      check("held_tc_low", tc_pulse, 0);
    end else begin
      check("idle_tc_low", tc_pulse, 0);
    end
    pv = out_valid;
  end

  task automatic drive(input logic [W-1:0] v, input int n);
    cnt_in = v;
    repeat (n) @(negedge clk);
  endtask

  int n0;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_delta", out_delta, 0);
    check("rst_tc", tc_pulse, 0);

    rst    = 1'b0;
    cnt_in = 4'd3;
    repeat (3) @(posedge clk);
    #1 check("lat_before_e4", out_valid, 0);
    @(posedge clk);
    #1 check("lat_at_e4", out_valid, 1);
    check("first_count", out_count, 3);
    check("first_delta", out_delta, 3);
    check("first_tc", tc_pulse, 0);
    @(negedge clk);
    drive(4'd3, 4);

    drive(4'd7, 8);
    n0 = samples;
    drive(4'd6, 1);
    drive(4'd4, 1);
    drive(4'd8, 8);
    check("glitch_samples", samples - n0, 1);
    check("glitch_value", seen_cnt, 8);

    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) drive(W'(v), 3);
    check("bp_valid_held", out_valid, 1);
    check("bp_count_held", out_count, 1);
    n0 = samples;
    out_ready = 1'b1;
    drive(4'd5, 8);
    check("bp_next_samples", samples - n0, 1);
    check("bp_next_count", seen_cnt, 5);
    check("bp_next_delta", seen_dlt, 4);

    drive(4'hE, 8);
    drive(4'h1, 8);
    check("wrap_up_delta", seen_dlt, 3);
    up = 1'b0;
    drive(4'hF, 8);
    check("wrap_down_delta", seen_dlt, 2);
    up = 1'b1;

    term_val = 4'hA;
    drive(4'hA, 8);
    check("term_hit", seen_tc, 1);
    drive(4'hB, 8);
    check("term_miss", seen_tc, 0);

    out_ready = 1'b0;
    term_val  = 4'd3;
    drive(4'd3, 8);
    check("hold_before_rst", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_count", out_count, 0);
    check("rst_hold_delta", out_delta, 0);
    n0 = samples;
    out_ready = 1'b1;
    drive(4'd0, 10);
    check("rst_zero_nosample", samples - n0, 0);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) up = ~up;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) term_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(W'($urandom_range(0, 15)), $urandom_range(1, 6));
    end

    out_ready = 1'b1;
    drive(cnt_in, 12);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
